// File: rtl/game_pkg.sv
// Shared constants for the judgement-line block: screen geometry, line
// colours, per-track state encoding and small decode helpers.
package game_pkg;

  localparam int TRACKS       = 6;
  localparam int TRK_W        = $clog2(TRACKS);
  localparam int TRACK_WIDTH  = 106;
  localparam int FLASH_FRAMES = 8;

  localparam logic [9:0] LINE_Y = 10'd440;
  localparam logic [9:0] LINE_W = 10'd3;

  localparam logic [15:0] COL_IDLE  = 16'hff0f;
  localparam logic [15:0] COL_FLASH = 16'hffff;
  localparam logic [15:0] COL_HOLD  = 16'hf0ff;
  localparam logic [15:0] COL_NONE  = 16'hfff0;

  // Encoding 3 is never produced and decodes as idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_HOLD  = 2'd2
  } trk_state_t;

  // Comparator chain against k*TRACK_WIDTH; anything past the last
  // boundary (including blanking) lands on the last track.
  function automatic logic [TRK_W-1:0] track_of(input logic [9:0] x);
    logic [TRK_W-1:0] idx;
    idx = '0;
    for (int k = 1; k < TRACKS; k++) begin
      if (int'(x) >= k * TRACK_WIDTH) idx = TRK_W'(k);
    end
    return idx;
  endfunction

  function automatic logic [15:0] line_colour(input logic [1:0] st);
    logic [15:0] c;
    case (st)
      ST_FLASH: c = COL_FLASH;
      ST_HOLD:  c = COL_HOLD;
      default:  c = COL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/track_line_ctrl_if.sv
// Pixel/key bus between the video timing source and the judgement-line
// layer. The master drives coordinates and keys; the slave returns the
// layer colour, committed track states and the frame pulse.
interface track_line_ctrl_if;
  import game_pkg::*;

  logic [9:0]          XPosition;
  logic [9:0]          YPosition;
  logic [TRACKS-1:0]   KeyPress;
  logic [15:0]         LayerOutput;
  logic [2*TRACKS-1:0] TrackState;
  logic                FrameTick;

  modport master (
    output XPosition, YPosition, KeyPress,
    input  LayerOutput, TrackState, FrameTick
  );

  modport slave (
    input  XPosition, YPosition, KeyPress,
    output LayerOutput, TrackState, FrameTick
  );

endinterface

// File: rtl/track_flash_fsm.sv
// One track's key sequencer: edge-detects the key, latches the press until
// the next frame tick, and runs the IDLE/FLASH/HOLD timer only on ticks so
// the committed state never changes mid-frame.
module track_flash_fsm
  import game_pkg::*;
#(
  parameter int FLASH_FRAMES_P = FLASH_FRAMES
) (
  input  logic       OriginalClk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       key,
  output logic [1:0] state
);

  localparam logic [3:0] FLASH_CNT = 4'(FLASH_FRAMES_P - 1);

  logic       prev;
  logic       pending;
  logic [3:0] cnt;
  trk_state_t st;
  logic       rise;
  logic       pend_now;

  // A rise coinciding with the tick counts toward that tick.
  assign rise     = key & ~prev;
  assign pend_now = pending | rise;

  // Key history, press latch and the tick-advanced track state machine.
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
      cnt     <= 4'd0;
      st      <= ST_IDLE;
    end else begin
      prev <= key;
      if (tick) begin
        pending <= rise;
        case (st)
          ST_FLASH: begin
            if (pend_now) begin
              cnt <= FLASH_CNT;
            end else if (cnt == 4'd0) begin
              st <= key ? ST_HOLD : ST_IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_HOLD: begin
            if (pend_now) begin
              st  <= ST_FLASH;
              cnt <= FLASH_CNT;
            end else if (!key) begin
              st <= ST_IDLE;
            end
          end
          default: begin
            if (pend_now) begin
              st  <= ST_FLASH;
              cnt <= FLASH_CNT;
            end else begin
              st <= ST_IDLE;
            end
          end
        endcase
      end else begin
        pending <= pend_now;
      end
    end
  end

  assign state = st;

endmodule

// File: rtl/track_line_ctrl.sv
// Judgement-line layer: detects the frame start, hosts one flash sequencer
// per track and renders the line rows through a two-stage pixel pipeline.
module track_line_ctrl
  import game_pkg::*;
(
  input  logic              OriginalClk,
  input  logic              Reset,
  track_line_ctrl_if.slave  bus
);

  logic [9:0]       prev_y;
  logic             tick;
  logic             frame_tick_p1;
  logic [1:0]       trk_st [TRACKS];
  logic             inline_p1;
  logic [TRK_W-1:0] trk_p1;
  logic [15:0]      layer_p2;

  assign tick = (prev_y != 10'd0) && (bus.YPosition == 10'd0);

  // Previous row register and the delayed frame-start pulse.
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      prev_y        <= 10'd0;
      frame_tick_p1 <= 1'b0;
    end else begin
      prev_y        <= bus.YPosition;
      frame_tick_p1 <= tick;
    end
  end

  for (genvar i = 0; i < TRACKS; i++) begin : g_trk
    track_flash_fsm #(.FLASH_FRAMES_P(FLASH_FRAMES)) u_fsm (
      .OriginalClk (OriginalClk),
      .Reset       (Reset),
      .tick        (tick),
      .key         (bus.KeyPress[i]),
      .state       (trk_st[i])
    );
    assign bus.TrackState[2*i +: 2] = trk_st[i];
  end

  // Stage 1: line-row qualifier and track index from the coordinates.
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      inline_p1 <= 1'b0;
      trk_p1    <= '0;
    end else begin
      inline_p1 <= (bus.YPosition > LINE_Y) && (bus.YPosition < LINE_Y + LINE_W);
      trk_p1    <= track_of(bus.XPosition);
    end
  end

  // Stage 2: colour from the committed state of the selected track.
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      layer_p2 <= COL_NONE;
    end else begin
      layer_p2 <= inline_p1 ? line_colour(trk_st[trk_p1]) : COL_NONE;
    end
  end

  assign bus.LayerOutput = layer_p2;
  assign bus.FrameTick   = frame_tick_p1;

endmodule

// File: doc/track_line_ctrl.md
Name: track_line_ctrl

Overview:
- Per-track sequencer and renderer for the judgement line (rows LINE_Y+1..LINE_Y+LINE_W-1) across 6 tracks.
- Key presses are edge-detected and latched, then committed only at frame boundaries (tear-free). Each track's flash/hold timer is sequenced from this.
- Drives the judgement-line layer colour per pixel into the layer mixer. Exports track state for scoring/debug.

Parameters:
- TRACKS, 6, number of tracks (state/ports sized by this)
- TRACK_WIDTH, 106, pixels per track column; X >= (TRACKS-1)*TRACK_WIDTH maps to last track
- LINE_Y, 440, line row base; line rows are Y > LINE_Y and Y < LINE_Y+LINE_W
- LINE_W, 3, line thickness bound
- FLASH_FRAMES, 8, frames a track flashes after a press (1..15)
- COL_IDLE, 16'hff0f, line colour, idle track
- COL_FLASH, 16'hffff, line colour, flashing track
- COL_HOLD, 16'hf0ff, line colour, key held after flash expired
- COL_NONE, 16'hfff0, transparent code outside line rows

Ports:
- OriginalClk  in  1  pixel-domain clock
- Reset  in  1  asynchronous, active-high reset
- XPosition  in  10  current pixel X
- YPosition  in  10  current pixel Y
- KeyPress  in  TRACKS  synchronised key levels, bit i = track i
- LayerOutput  out  16  layer colour, registered
- TrackState  out  2*TRACKS  committed state per track, {1:0}=track 0
- FrameTick  out  1  one-cycle pulse at frame start, registered

Behaviour:
- Reset values: LayerOutput=COL_NONE, TrackState=0 (IDLE), FrameTick=0. All counters, pending latches and previous-key/previous-Y registers are cleared.
- Frame tick: the internal tick is true in the cycle where the registered previous Y != 0 and the current YPosition == 0. FrameTick output is that tick delayed 1 cycle.
- Key edge: rise[i] = KeyPress[i] & ~prev[i], where prev is registered every cycle. Any rise sets pending[i], which stays set until the next tick. A rise in the same cycle as a tick is captured for that tick.
- Per-track FSM, advancing only on tick. State encoding: IDLE=0, FLASH=1, HOLD=2 (3 is unused and decodes as IDLE).
  - IDLE: if pending, go to FLASH with cnt=FLASH_FRAMES-1.
  - FLASH: if pending, restart with cnt=FLASH_FRAMES-1. Else if cnt==0, go to HOLD if KeyPress[i] else IDLE. Else cnt-1.
  - HOLD: if pending, go to FLASH (restart). Else if !KeyPress[i], go to IDLE.
  - pending[i] clears on tick unless a new rise occurs in that same cycle.
- cnt is 4 bits. With FLASH_FRAMES=1 the track flashes for exactly one frame.
- Pixel path, 2-cycle latency from X/Y to LayerOutput:
  - Stage 1 registers inline = (Y>LINE_Y)&(Y<LINE_Y+LINE_W) and trk = the track index from a comparator chain against k*TRACK_WIDTH. No divider is used.
  - Stage 2 outputs COL_NONE if !inline, else the colour for the committed state of trk.
- The state used by the pixel path changes only on tick, so no mid-frame colour change is possible.
- X >= 640 or Y >= 480 (blanking): same rules apply and no special case is made. The mixer ignores blanking.
- Reset asserted mid-frame clears everything immediately. The first tick after release starts normally.

Decomposition:
- Shared package (game_pkg): TRACKS, TRACK_WIDTH, LINE_Y, LINE_W, the colour constants, and the state encoding IDLE/FLASH/HOLD.
- One sub-module, track_flash_fsm, instantiated TRACKS times via generate. It contains prev key, pending, cnt and state, with inputs tick and key and a 2-bit state output.
- The top level holds tick detection and the pixel pipeline.

Test Plan:
- Reset, then scan a frame → LayerOutput=16'hff0f at (X=50,Y=441), 16'hfff0 at (50,440) and (50,443). TrackState=0. Output lags input by 2 cycles.
- Pulse KeyPress[2] mid-frame at Y=200 → no change this frame. After the next tick, track 2 (X=212..317) shows 16'hffff for 8 frames, then 16'hff0f. Other tracks stay 16'hff0f.
- Hold KeyPress[4] through 10 frames → 8 frames FLASH, then HOLD with 16'hf0ff at X=430. Release → IDLE at the next tick.
- Re-press track 0 during FLASH at frame 5 → counter restarts, so FLASH lasts 13 frames total.
- KeyPress[1] rises in the exact tick cycle → FLASH committed on that tick. Simultaneous rises on all 6 tracks → all FLASH together.
- Assert Reset mid-FLASH on track 3 → TrackState=0 and LayerOutput=16'hfff0 immediately. After release, no flash until a new press.
